// File: rtl/counter_event_arbiter.sv
// Four edge-event sources (KEY/SW) feed saturating pending counters that a round-robin
// arbiter drains into two 7-bit up/down counters. Optional input debounce: DEBOUNCE_FILTER_EN.
module counter_event_arbiter #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] KEY,
  input  logic [1:0] SW,
  input  logic       clr_drop,
  output logic [6:0] count_KEY,
  output logic [6:0] count_SW,
  output logic [7:0] pending,
  output logic [3:0] grant,
  output logic [3:0] drop_flag
);

  // Source order: {SW[1], SW[0], KEY[1], KEY[0]} = {src3, src2, src1, src0}
  logic [3:0] raw;
  logic [3:0] cur;
  logic [3:0] prev;
  logic [3:0] ev;

  assign raw = {SW[1], SW[0], KEY[1], KEY[0]};

`ifdef DEBOUNCE_FILTER_EN
  logic [3:0]  filt;
  logic [15:0] db_cnt [4];

  // filt follows raw only after DB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst) begin
      filt <= raw;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (raw[i] != filt[i]) begin
          if (db_cnt[i] == 16'(DB_CYCLES - 1)) begin
            filt[i]   <= raw[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign cur = filt;
`else
  assign cur = raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst) prev <= raw;
    else      prev <= cur;
  end

  assign ev = {prev[3] & ~cur[3], ~prev[2] & cur[2], ~prev[1] & cur[1], prev[0] & ~cur[0]};

  logic [1:0] pend     [4];
  logic [1:0] pend_nxt [4];
  logic [3:0] drop_set;
  logic [3:0] gnt_vec;
  logic [1:0] ptr;
  logic [1:0] sel;
  logic [1:0] idx;
  logic       sel_valid;

  assign pending = {pend[3], pend[2], pend[1], pend[0]};

  // Round-robin search starting one past the last granted source
  always_comb begin
    sel_valid = 1'b0;
    sel       = ptr;
    idx       = ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!sel_valid && pend[idx] != 2'd0) begin
        sel_valid = 1'b1;
        sel       = idx;
      end
    end
  end

  always_comb begin
    drop_set = '0;
    gnt_vec  = '0;
    for (int i = 0; i < 4; i++) begin
      gnt_vec[i]  = sel_valid && (sel == 2'(i));
      pend_nxt[i] = pend[i];
      if (ev[i] && !gnt_vec[i]) begin
        if (pend[i] == 2'd3) drop_set[i] = 1'b1;
        else                 pend_nxt[i] = pend[i] + 2'd1;
      end else if (!ev[i] && gnt_vec[i]) begin
        pend_nxt[i] = pend[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) pend[i] <= 2'd0;
      ptr       <= 2'd3;
      count_KEY <= '0;
      count_SW  <= '0;
      grant     <= '0;
      drop_flag <= '0;
    end else begin
      for (int i = 0; i < 4; i++) pend[i] <= pend_nxt[i];
      // A drop in the same cycle as clr_drop wins
      drop_flag <= (clr_drop ? 4'b0000 : drop_flag) | drop_set;
      grant     <= gnt_vec;
      if (sel_valid) begin
        ptr <= sel;
        case (sel)
          2'd0: count_KEY <= count_KEY + 7'd1;
          2'd1: count_KEY <= count_KEY - 7'd1;
          2'd2: count_SW  <= count_SW + 7'd1;
          default: count_SW <= count_SW - 7'd1;
        endcase
      end
    end
  end

endmodule

// File: doc/counter_event_arbiter.md
COUNTER_EVENT_ARBITER -- requirements
Module: counter_event_arbiter

Interface
REQ-001 Parameter DB_CYCLES, default 4: stability length in clk cycles for the debounce filter; only used when DEBOUNCE_FILTER_EN is defined; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 KEY  input  2  push-buttons, already synchronized to clk.
REQ-005 SW  input  2  slide switches, already synchronized to clk.
REQ-006 clr_drop  input  1  synchronous clear of drop_flag; active-high.
REQ-007 count_KEY  output  7  KEY event counter, registered.
REQ-008 count_SW  output  7  SW event counter, registered.
REQ-009 pending  output  8  per-source 2-bit pending counts, {src3,src2,src1,src0}, registered.
REQ-010 grant  output  4  one-hot pulse for the source applied at the most recent edge; 0 when no source was applied; registered.
REQ-011 drop_flag  output  4  sticky per-source flag for a lost event, registered.

Function
REQ-012 Sources: src0 = KEY[0] falling edge (count_KEY +1); src1 = KEY[1] rising edge (count_KEY -1); src2 = SW[0] rising edge (count_SW +1); src3 = SW[1] falling edge (count_SW -1).
REQ-013 Edge detection compares the current input with a 1-cycle delayed copy; each source generates at most one event per cycle.
REQ-014 Each detected event increments that source's pending count at the same edge; events are never discarded by priority.
REQ-015 Each cycle the arbiter selects exactly one source with a nonzero pending count, round-robin, searching from (last granted + 1) mod 4.
REQ-016 The selected source has its pending count decremented, its counter updated, and grant set to its one-hot code, all at the same edge.
REQ-017 If no source is pending, grant = 4'b0000 and the counters hold.
REQ-018 Latency: for an input change sampled at edge n with no other pending work, the counter updates at edge n+1.
REQ-019 Counters wrap modulo 128: 127 + 1 = 0 and 0 - 1 = 127.
REQ-020 Pending count saturates at 3. An event that arrives when the count is 3 and the source is not granted that cycle is lost and sets that source's drop_flag bit.
REQ-021 An event that arrives in the same cycle its source is granted leaves the count unchanged and is not a drop, even at 3.
REQ-022 drop_flag bits are cleared only by reset or by clr_drop = 1. A drop and clr_drop in the same cycle leave the bit set.
REQ-023 count_KEY and count_SW update independently, at most one source per cycle in total.

Reset
REQ-024 On rst = 0 at a clock edge: count_KEY = 0, count_SW = 0, pending = 0, grant = 0, drop_flag = 0, and the round-robin pointer = 3 (so src0 is searched first).
REQ-025 During reset the edge-delay registers (and filter outputs, when compiled in) load the current raw KEY/SW values, so no spurious event follows reset release.
REQ-026 Reset applied mid-operation discards all pending events, with no counter update in that cycle.

Configuration
REQ-027 Macro DEBOUNCE_FILTER_EN.
- Defined: each of the 4 inputs passes through a stability filter; the filtered value changes only after the raw input has differed from it for DB_CYCLES consecutive cycles; edge detection uses the filtered value; latency (REQ-018) grows by DB_CYCLES.
- Undefined: edge detection uses the raw inputs; no filter logic is instantiated; DB_CYCLES is ignored.

Verification
REQ-028 Reset release with KEY = 2'b11 and SW = 2'b00, inputs idle for 10 cycles -> all outputs 0 and no grant pulses.
REQ-029 KEY[0] falls and SW[0] rises in the same cycle -> grant = 0001 at the next edge, then 0100; count_KEY = 1, count_SW = 1; pending returns to 0.
REQ-030 All 4 sources fire in one cycle, with the pointer at reset value -> grants 0001, 0010, 0100, 1000 on consecutive edges; count_KEY = 0, count_SW = 0.
REQ-031 Stall with src2 pending at 3 while src0 through src3 are continuously re-pending, then another SW[0] rise while src2 is not granted -> drop_flag[2] = 1; it stays 1 until clr_drop pulses, then reads 0.
REQ-032 count_SW = 0 and one src3 event -> count_SW = 127. Then one src2 event -> count_SW = 0.
REQ-033 With DEBOUNCE_FILTER_EN and DB_CYCLES = 4: a 3-cycle KEY[0] low glitch produces no event. A 4-cycle low gives count_KEY = 1 at the 5th edge after the fall.
